// File: rtl/fir_mem_sequencer.sv
// fir_mem_sequencer: streams TAPS reads out of a circular sample buffer and returns the signed
// dot product with the stored coefficients. Build option FIR_SAT_EN: shift and saturate the result.
module fir_mem_sequencer #(
    parameter int TAPS      = 8,
    parameter int BUF_BASE  = 0,
    parameter int BUF_DEPTH = 8,
    parameter int ACC_W     = 20,
    parameter int SHIFT     = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             base_addr,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_idx,
    input  logic [7:0]              coef_data,
    output logic                    mem_RE,
    output logic [31:0]             Dir,
    input  logic [7:0]              mem_data,
    output logic                    busy,
    output logic [ACC_W-1:0]        result,
    output logic                    result_valid,
    input  logic                    result_ready
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int DIDX_W = $clog2(BUF_DEPTH);
    localparam int CNT_W  = $clog2(TAPS + 2);
    localparam logic [31:0]      BASE_V     = 32'(BUF_BASE);
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] LAST_ACC   = CNT_W'(TAPS + 1);
    localparam logic [CNT_W-1:0] FIRST_ACC  = CNT_W'(2);

    if (TAPS < 2) begin : g_bad_taps
        $error("TAPS must be at least 2");
    end
    if (BUF_DEPTH < TAPS || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("BUF_DEPTH must be a power of two and at least TAPS");
    end
    if (ACC_W < 16 + $clog2(TAPS) || SHIFT < 0 || SHIFT >= ACC_W) begin : g_bad_width
        $error("ACC_W too narrow or SHIFT out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // cyc counts edges since the start edge; sample for tap cyc-2 is on mem_data
    logic [CNT_W-1:0]        cyc;
    logic [CNT_W-1:0]        tap_sel;
    logic [DIDX_W-1:0]       idx;
    logic [DIDX_W-1:0]       idx_dec;
    logic [DIDX_W-1:0]       off;
    logic signed [7:0]       coef [TAPS];
    logic signed [7:0]       coef_cur;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] final_sum;
    logic [ACC_W-1:0]        result_d;

    logic load_start;
    logic coef_en;
    logic drive_tap;
    logic stop_issue;
    logic acc_en;
    logic finish;
    logic release_res;

    // The modulo keeps every base_addr bit in the expression; for a power-of-two depth it is a slice
    assign off     = DIDX_W'((base_addr - BASE_V) % 32'(BUF_DEPTH));
    assign idx_dec = idx - DIDX_W'(1);
    assign tap_sel = cyc - FIRST_ACC;

    always_comb begin
        coef_cur = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (tap_sel == CNT_W'(i)) coef_cur = coef[i];
        end
    end

    assign prod      = $signed(mem_data) * coef_cur;
    assign prod_ext  = {{(ACC_W - 16){prod[15]}}, prod};
    assign final_sum = acc + prod_ext;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = final_sum >>> SHIFT;
        if (shifted > SAT_HI)      result_d = SAT_HI;
        else if (shifted < SAT_LO) result_d = SAT_LO;
        else                       result_d = shifted;
    end
`else
    assign result_d = final_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   if (cyc == LAST_ISSUE) state_next = DRAIN;
            DRAIN:   if (cyc == LAST_ACC) state_next = DONE;
            DONE:    if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_start  = 1'b0;
        coef_en     = 1'b0;
        drive_tap   = 1'b0;
        stop_issue  = 1'b0;
        acc_en      = 1'b0;
        finish      = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                coef_en    = coef_we;
                load_start = start;
            end
            ISSUE: begin
                drive_tap  = (cyc < LAST_ISSUE);
                stop_issue = (cyc == LAST_ISSUE);
                acc_en     = (cyc >= FIRST_ACC);
            end
            DRAIN: begin
                acc_en = (cyc != LAST_ACC);
                finish = (cyc == LAST_ACC);
            end
            DONE:    release_res = result_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc          <= '0;
            idx          <= '0;
            mem_RE       <= 1'b1;
            Dir          <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else begin
            busy <= (state_next != IDLE);
            // A write on the start edge lands before its tap is first multiplied
            for (int i = 0; i < TAPS; i++) begin
                if (coef_en && coef_idx == IDX_W'(i)) coef[i] <= coef_data;
            end
            if (load_start) begin
                acc    <= '0;
                idx    <= off;
                Dir    <= BASE_V + 32'(off);
                mem_RE <= 1'b0;
                cyc    <= CNT_W'(1);
            end else if (state == ISSUE || state == DRAIN) begin
                cyc <= cyc + CNT_W'(1);
            end
            if (drive_tap) begin
                idx <= idx_dec;
                Dir <= BASE_V + 32'(idx_dec);
            end
            if (stop_issue) mem_RE <= 1'b1;
            if (acc_en)     acc <= final_sum;
            if (finish) begin
                result       <= result_d;
                result_valid <= 1'b1;
            end
            if (release_res) result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_mem_sequencer.sv
// Bench for fir_mem_sequencer: registered memory responder, dot-product reference model, scenario tasks.
module tb_fir_mem_sequencer;

    localparam int TAPS      = 8;
    localparam int BUF_BASE  = 0;
    localparam int BUF_DEPTH = 8;
    localparam int ACC_W     = 20;
    localparam int SHIFT     = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      base_addr = '0;
    logic             coef_we = 1'b0;
    logic [2:0]       coef_idx = '0;
    logic [7:0]       coef_data = '0;
    logic             mem_RE;
    logic [31:0]      Dir;
    logic [7:0]       mem_data = '0;
    logic             busy;
    logic [ACC_W-1:0] result;
    logic             result_valid;
    logic             result_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    logic [7:0]       mem [BUF_DEPTH];
    logic [7:0]       coef_m [TAPS];
    logic [31:0]      exp_q [$];
    logic [31:0]      obs_dir [$];
    int               obs_lat;
    logic [ACC_W-1:0] obs_res;

    fir_mem_sequencer #(
        .TAPS(TAPS), .BUF_BASE(BUF_BASE), .BUF_DEPTH(BUF_DEPTH), .ACC_W(ACC_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
        .mem_RE(mem_RE), .Dir(Dir), .mem_data(mem_data), .busy(busy),
        .result(result), .result_valid(result_valid), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_RE) mem_data <= mem[3'(Dir - 32'(BUF_BASE))];
    end

    function automatic int off_of(input logic [31:0] base);
        return int'((base - 32'(BUF_BASE)) % BUF_DEPTH);
    endfunction

    function automatic logic [ACC_W-1:0] model(input logic [31:0] base);
        int sum;
        int sh;
        logic signed [ACC_W-1:0] w;
        sum = 0;
        for (int i = 0; i < TAPS; i++)
            sum += int'($signed(mem[(off_of(base) - i + BUF_DEPTH) % BUF_DEPTH])) * int'($signed(coef_m[i]));
        w = ACC_W'(sum);
`ifdef FIR_SAT_EN
        sh = int'(w) >>> SHIFT;
        if (sh > 127) sh = 127;
        if (sh < -128) sh = -128;
`else
        sh = int'(w);
`endif
        return ACC_W'(sh);
    endfunction

    task automatic build_exp(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < TAPS; i++)
            exp_q.push_back(32'(BUF_BASE) + 32'((off_of(base) - i + BUF_DEPTH) % BUF_DEPTH));
    endtask

    task automatic load_coefs();
        for (int i = 0; i < TAPS; i++) begin
            @(negedge clk);
            coef_we = 1'b1; coef_idx = 3'(i); coef_data = coef_m[i];
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Pulse start (optionally with a coefficient write on the same edge) and collect reads until result_valid
    task automatic run_eval(input logic [31:0] base, input bit wr, input logic [2:0] widx, input logic [7:0] wdata);
        obs_dir.delete();
        obs_lat = -1;
        obs_res = 'x;
        @(negedge clk);
        start = 1'b1; base_addr = base;
        coef_we = wr; coef_idx = widx; coef_data = wdata;
        @(negedge clk);
        start = 1'b0; coef_we = 1'b0; base_addr = $urandom;
        for (int k = 0; k < 40; k++) begin
            if (!mem_RE) obs_dir.push_back(Dir);
            if (result_valid) begin
                obs_lat = k;
                obs_res = result;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (mem_RE !== 1'b1) begin failures++; $display("FAIL reset_mem_RE got=%b exp=1", mem_RE); end
        checks++; if (Dir !== 32'd0) begin failures++; $display("FAIL reset_Dir got=%0d exp=0", Dir); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'(i + 1);
        for (int i = 0; i < TAPS; i++) coef_m[i] = 8'd1;
        load_coefs();
        build_exp(32'd7);
        run_eval(32'd7, 1'b0, 3'd0, 8'd0);
        checks++; if (obs_lat !== TAPS + 1) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", obs_lat, TAPS + 1); end
        checks++; if (obs_dir.size() !== exp_q.size()) begin failures++; $display("FAIL basic_read_count got=%0d exp=%0d", obs_dir.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_dir.size(); i++) begin
            checks++; if (obs_dir[i] !== exp_q[i]) begin failures++; $display("FAIL basic_dir[%0d] got=%0d exp=%0d", i, obs_dir[i], exp_q[i]); end
        end
        checks++; if (obs_res !== model(32'd7)) begin failures++; $display("FAIL basic_result got=%0d exp=%0d", $signed(obs_res), $signed(model(32'd7))); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'($urandom);
        mem[7] = 8'hFB;
        for (int i = 0; i < TAPS; i++) coef_m[i] = 8'd0;
        coef_m[3] = 8'd2;
        load_coefs();
        build_exp(32'd2);
        run_eval(32'd2, 1'b0, 3'd0, 8'd0);
        checks++; if (obs_dir.size() !== exp_q.size()) begin failures++; $display("FAIL wrap_read_count got=%0d exp=%0d", obs_dir.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_dir.size(); i++) begin
            checks++; if (obs_dir[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_dir[%0d] got=%0d exp=%0d", i, obs_dir[i], exp_q[i]); end
        end
        checks++; if (obs_res !== model(32'd2)) begin failures++; $display("FAIL wrap_result got=%0d exp=%0d", $signed(obs_res), $signed(model(32'd2))); end
    endtask

    task automatic test_extremes();
        logic [7:0] cval [2];
        cval[0] = 8'h80;
        cval[1] = 8'h7F;
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'h80;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < TAPS; i++) coef_m[i] = cval[c];
            load_coefs();
            run_eval(32'd5, 1'b0, 3'd0, 8'd0);
            checks++; if (obs_res !== model(32'd5)) begin failures++; $display("FAIL extreme_result[%0d] got=%0d exp=%0d", c, $signed(obs_res), $signed(model(32'd5))); end
            checks++; if (obs_lat !== TAPS + 1) begin failures++; $display("FAIL extreme_latency[%0d] got=%0d exp=%0d", c, obs_lat, TAPS + 1); end
        end
    endtask

    task automatic test_same_edge();
        logic [31:0] base;
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < TAPS; i++) coef_m[i] = 8'd0;
        load_coefs();
        base = $urandom;
        coef_m[0] = 8'($urandom_range(1, 127));
        mem[off_of(base)] = 8'($urandom_range(1, 127));
        run_eval(base, 1'b1, 3'd0, coef_m[0]);
        checks++; if (obs_res !== model(base)) begin failures++; $display("FAIL same_edge_result got=%0d exp=%0d", $signed(obs_res), $signed(model(base))); end
    endtask

    task automatic test_random();
        logic [31:0] base;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'($urandom);
            for (int i = 0; i < TAPS; i++) coef_m[i] = 8'($urandom);
            load_coefs();
            base = $urandom;
            build_exp(base);
            run_eval(base, 1'b0, 3'd0, 8'd0);
            checks++; if (obs_res !== model(base)) begin failures++; $display("FAIL random_result[%0d] got=%0d exp=%0d", n, $signed(obs_res), $signed(model(base))); end
            checks++; if (obs_lat !== TAPS + 1) begin failures++; $display("FAIL random_latency[%0d] got=%0d exp=%0d", n, obs_lat, TAPS + 1); end
            checks++; if (obs_dir.size() !== TAPS || obs_dir[0] !== exp_q[0]) begin failures++; $display("FAIL random_reads[%0d] count=%0d first=%0d exp_first=%0d", n, obs_dir.size(), obs_dir.size() > 0 ? obs_dir[0] : 32'hFFFFFFFF, exp_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        logic [ACC_W-1:0] held;
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < TAPS; i++) coef_m[i] = 8'($urandom);
        load_coefs();
        base = $urandom;
        result_ready = 1'b0;
        run_eval(base, 1'b0, 3'd0, 8'd0);
        held = obs_res;
        checks++; if (held !== model(base)) begin failures++; $display("FAIL bp_result got=%0d exp=%0d", $signed(held), $signed(model(base))); end
        for (int c = 0; c < 10; c++) begin
            start = 1'($urandom_range(0, 1));
            coef_we = 1'b1; coef_idx = 3'($urandom); coef_data = 8'($urandom);
            base_addr = $urandom;
            @(negedge clk);
            checks++; if (result_valid !== 1'b1 || result !== held) begin failures++; $display("FAIL bp_hold[%0d] valid=%b result=%0d exp_result=%0d", c, result_valid, $signed(result), $signed(held)); end
            checks++; if (mem_RE !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL bp_idle_bus[%0d] mem_RE=%b busy=%b exp 1/1", c, mem_RE, busy); end
        end
        start = 1'b0; coef_we = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release valid=%b busy=%b exp 0/0", result_valid, busy); end
        checks++; if (result !== held) begin failures++; $display("FAIL bp_result_kept got=%0d exp=%0d", $signed(result), $signed(held)); end
        run_eval(base, 1'b0, 3'd0, 8'd0);
        checks++; if (obs_res !== model(base)) begin failures++; $display("FAIL bp_coefs_kept got=%0d exp=%0d", $signed(obs_res), $signed(model(base))); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] base;
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'($urandom_range(1, 127));
        for (int i = 0; i < TAPS; i++) coef_m[i] = 8'($urandom_range(1, 127));
        load_coefs();
        base = $urandom;
        build_exp(base);
        @(negedge clk);
        start = 1'b1; base_addr = base;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (mem_RE !== 1'b0 || Dir !== exp_q[4]) begin failures++; $display("FAIL mid_tap4 mem_RE=%b Dir=%0d exp 0/%0d", mem_RE, Dir, exp_q[4]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_RE !== 1'b1 || Dir !== 32'd0) begin failures++; $display("FAIL mid_async_bus mem_RE=%b Dir=%0d exp 1/0", mem_RE, Dir); end
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin failures++; $display("FAIL mid_async_flags busy=%b valid=%b exp 0/0", busy, result_valid); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < TAPS; i++) coef_m[i] = 8'd0;
        run_eval(base, 1'b0, 3'd0, 8'd0);
        checks++; if (obs_res !== model(base)) begin failures++; $display("FAIL mid_cleared_coefs got=%0d exp=%0d", $signed(obs_res), $signed(model(base))); end
        checks++; if (obs_lat !== TAPS + 1) begin failures++; $display("FAIL mid_latency got=%0d exp=%0d", obs_lat, TAPS + 1); end
    endtask

    initial begin
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_extremes();
        test_same_edge();
        test_random();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_mem_sequencer.md
Name: fir_mem_sequencer

Overview:
- Filter engine directly upstream of the sample data memory: issues read strobes and addresses into a circular sample buffer, consumes the returned 8-bit samples, and computes a TAPS-tap signed FIR dot product against internally stored coefficients.
- Delivers one accumulated result per start request over a valid/ready handshake to the downstream output stage.

Parameters:
- TAPS, 8, number of filter taps; must be ≥ 2.
- BUF_BASE, 0, absolute address of the first circular sample-buffer entry.
- BUF_DEPTH, 8, entries in the circular buffer; power of two and ≥ TAPS.
- ACC_W, 20, accumulator and result width; must be ≥ 16+clog2(TAPS).
- SHIFT, 7, right-shift applied only under FIR_SAT_EN.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one filter evaluation; sampled only in IDLE.
- base_addr  in  32  address of the newest sample (tap 0).
- coef_we  in  1  coefficient write strobe.
- coef_idx  in  clog2(TAPS)  coefficient index.
- coef_data  in  8  signed coefficient value.
- mem_RE  out  1  memory read enable, active-low.
- Dir  out  32  memory read address.
- mem_data  in  8  registered memory read data (memory Data_out).
- busy  out  1  high whenever the state is not IDLE.
- result  out  ACC_W  signed filter output.
- result_valid  out  1  result is held valid.
- result_ready  in  1  downstream accepts result.

Behaviour:
- Reset (async, any state):
  - state=IDLE; mem_RE=1; Dir=0; result=0; result_valid=0; busy=0.
  - Accumulator and all coefficients cleared to 0.
  - Any in-flight evaluation is abandoned, with no partial result.
- All outputs are registered.
- Memory contract: memory registers the data at the edge after the engine drives Dir with mem_RE=0. The engine samples mem_data at the following edge, giving a 2-edge read pipeline.
- Index math: off = (base_addr - BUF_BASE) mod BUF_DEPTH, taken from the low log2(BUF_DEPTH) bits. Tap i address = BUF_BASE + ((off - i) mod BUF_DEPTH), so the index decrements and wraps from 0 to BUF_DEPTH-1.
- IDLE:
  - On an edge with start=1: acc cleared, Dir=tap0 address, mem_RE=0, go to ISSUE.
  - Coefficient writes are accepted here.
- ISSUE:
  - Each edge drives the next tap address with mem_RE=0 until tap TAPS-1 has been driven.
  - At the next edge: mem_RE=1, go to DRAIN.
  - From the second edge after entry, each edge adds sext(mem_data*coef[i]) to acc, in order i=0..TAPS-1. The product is signed 8x8 → 16, sign-extended to ACC_W.
- DRAIN:
  - Accumulates the final outstanding taps.
  - On the edge accumulating tap TAPS-1: result=acc+product, result_valid=1, go to DONE.
- Timing: result_valid rises TAPS+1 edges after the start edge (9 for defaults). No bubbles occur between tap reads.
- DONE:
  - result and result_valid are held stable while result_ready=0.
  - On an edge with result_valid & result_ready: result_valid=0, go to IDLE. result keeps its last value.
  - A new start is accepted no earlier than the edge after the return to IDLE.
- Ignored inputs:
  - start outside IDLE is ignored and not queued.
  - coef_we in ISSUE, DRAIN or DONE is ignored. This keeps coefficients constant during an evaluation.
  - A coefficient write and start on the same IDLE edge: the write takes effect and is used by the evaluation started on that edge.
  - base_addr is sampled only on the start edge.
- Overflow: none at legal ACC_W. The accumulator is two's-complement wrapping by construction.

Optional Feature:
- Macro FIR_SAT_EN.
- Defined: result = sign-extend to ACC_W of sat8(acc >>> SHIFT), where the arithmetic shift is saturated to [-128, 127]. Timing is unchanged.
- Undefined: result = raw ACC_W accumulator, and SHIFT is unused.

Test Plan:
- Defaults; coefs all 1; memory[0..7]=1..8; base_addr=7; start pulse → Dir sequence 7,6,5,4,3,2,1,0 with mem_RE=0 for exactly 8 cycles; result_valid at edge 9; result=36.
- Wrap: base_addr=2; coef[3]=2, others 0; memory[7]=-5 → Dir sequence 2,1,0,7,6,5,4,3; result=-10.
- Extremes: all samples -128, all coefs -128 → result=131072 with no wrap. With FIR_SAT_EN and SHIFT=7 → result=127. All samples -128, coefs all +127 → result=-130048. With FIR_SAT_EN → -128.
- Backpressure: hold result_ready=0 for 10 cycles, pulse start and coef_we meanwhile → result and result_valid stable, no new reads, coefficients unchanged. Release ready → IDLE next edge, busy=0.
- Reset asserted at tap 4 of ISSUE → asynchronously mem_RE=1, Dir=0, busy=0, result_valid=0, coefs 0. A subsequent run with coefs unloaded gives result=0.
